quad_poly_eval: RTL
===================

QUAD_POLY_EVAL -- requirements
Module: quad_poly_eval

Interface
REQ-001 SHALL have parameter A, default 5, signed 5-bit coefficient of x^2.
REQ-002 SHALL have parameter B, default 8, signed 5-bit coefficient of x.
REQ-003 SHALL have parameter C, default -4, signed 5-bit coefficient of y^2.
REQ-004 SHALL have parameter D, default 3, signed 5-bit coefficient of y.
REQ-005 SHALL have parameter E, default 6, signed 5-bit coefficient of z^2.
REQ-006 SHALL have parameter F, default -2, signed 5-bit coefficient of z.
REQ-007 SHALL have parameter G, default 13, signed 5-bit constant term.
REQ-008 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-009 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port en, input, 1 bit: start request, sampled only in IDLE.
REQ-011 SHALL have port in0, input, 4 bits: unsigned x.
REQ-012 SHALL have port in1, input, 4 bits: unsigned y.
REQ-013 SHALL have port in2, input, 4 bits: unsigned z.
REQ-014 SHALL have port done, output, 1 bit: result valid, level signal.
REQ-015 SHALL have port out, output, 19 bits signed: F(x,y,z)=Ax^2+Bx+Cy^2+Dy+Ez^2+Fz+G.

Function
REQ-016 SHALL implement FSM states IDLE, TX2, TX1, TY2, TY1, TZ2, TZ1, DONE.
REQ-017 In IDLE with en=1 at a rising edge: SHALL latch in0/in1/in2, load accumulator with sign-extended G, go to TX2.
REQ-018 SHALL use one shared signed multiplier; each of TX2..TZ1 adds exactly one term (coef x operand) to the accumulator, then advances in listed order.
REQ-019 Square operands SHALL be formed as unsigned 8-bit (max 225) and zero-extended; coefficients sign-extended; all products and sums SHALL be 19-bit signed (no overflow possible; no saturation).
REQ-020 On TZ1 -> DONE transition SHALL load out with the final accumulator value and set done=1.
REQ-021 Latency SHALL be exactly 7 rising edges from the edge sampling en=1 to the edge at which done rises.
REQ-022 en changes and in0..in2 changes after the start edge SHALL NOT affect the running evaluation.
REQ-023 out SHALL change only on entry to DONE or on reset; out SHALL hold its value otherwise.
REQ-024 en=0 in IDLE SHALL keep the FSM in IDLE with done=0.

Reset
REQ-025 rst=0 SHALL immediately, independent of clk, force state=IDLE, done=0, out=0, accumulator=0, latched inputs=0.
REQ-026 Reset asserted mid-evaluation SHALL abort it; no partial result SHALL appear on out.
REQ-027 After rst returns high, the first rising edge with en=1 SHALL start a new evaluation.

Configuration
REQ-028 Macro QUAD_POLY_REARM_EN SHALL select restart behaviour.
REQ-029 Without QUAD_POLY_REARM_EN: DONE SHALL be sticky (done=1, out held) until rst=0.
REQ-030 With QUAD_POLY_REARM_EN: in DONE, en=0 at a rising edge SHALL return to IDLE and clear done, out retained; a later en=1 starts a new evaluation without reset.

Verification
REQ-031 Reset: rst=0 with en=1, inputs random -> done=0, out=0 immediately and for all reset cycles.
REQ-032 Defaults, in0=in1=in2=0, en=1 -> done rises on 7th edge, out=13; in0=2 -> out=49; in1=2 (others 0) -> out=3; in2=1 -> out=17.
REQ-033 Corner: in0=in1=in2=15 -> out=1723; in0=in1=in2=0 with A..G=-16 -> out=-16.
REQ-034 Mid-op: start with in0=2, toggle en and change in0 to 9 on edge 3 -> out=49; separate run asserting rst=0 on edge 4 -> done=0, out=0, then new start yields correct result.
REQ-035 Sticky (macro off): after done with out=13, drop en, change inputs for 20 cycles -> done=1, out=13 unchanged.
REQ-036 Rearm (macro on): after out=13, en=0 one edge -> done=0, out=13; then in0=1, en=1 -> 7 edges later done=1, out=26.

Source files
------------

// File: rtl/quad_poly_eval.sv
// Sequential evaluator for F(x,y,z)=Ax^2+Bx+Cy^2+Dy+Ez^2+Fz+G using one shared multiplier.
// Define QUAD_POLY_REARM_EN to let DONE return to IDLE when en drops; otherwise DONE is sticky until reset.
//
// state | meaning
// IDLE  | waiting for en; latches x,y,z and seeds accumulator with G
// TX2   | accumulate A*x^2
// TX1   | accumulate B*x
// TY2   | accumulate C*y^2
// TY1   | accumulate D*y
// TZ2   | accumulate E*z^2
// TZ1   | accumulate F*z, publish result
// DONE  | result valid on out, done high
module quad_poly_eval #(
  parameter logic signed [4:0] A = 5,
  parameter logic signed [4:0] B = 8,
  parameter logic signed [4:0] C = -4,
  parameter logic signed [4:0] D = 3,
  parameter logic signed [4:0] E = 6,
  parameter logic signed [4:0] F = -2,
  parameter logic signed [4:0] G = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         in0,
  input  logic [3:0]         in1,
  input  logic [3:0]         in2,
  output logic               done,
  output logic signed [18:0] out
);

  typedef enum logic [2:0] {IDLE, TX2, TX1, TY2, TY1, TZ2, TZ1, DONE} state_t;

  state_t             state, state_nxt;
  logic [3:0]         x_q, y_q, z_q;
  logic signed [18:0] acc;
  logic signed [18:0] out_q;
  logic signed [4:0]  coef;
  logic [7:0]         opnd;
  logic [7:0]         x_sq, y_sq, z_sq;
  logic signed [18:0] prod;
  logic               term_active;

  assign x_sq = {4'b0, x_q} * {4'b0, x_q};
  assign y_sq = {4'b0, y_q} * {4'b0, y_q};
  assign z_sq = {4'b0, z_q} * {4'b0, z_q};

  // Operands are non-negative, so zero-extension keeps the product signed-correct.
  assign prod = $signed({{14{coef[4]}}, coef}) * $signed({11'b0, opnd});

  always_comb begin
    state_nxt   = state;
    coef        = '0;
    opnd        = '0;
    term_active = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = TX2;
      TX2: begin coef = A; opnd = x_sq;        term_active = 1'b1; state_nxt = TX1; end
      TX1: begin coef = B; opnd = {4'b0, x_q}; term_active = 1'b1; state_nxt = TY2; end
      TY2: begin coef = C; opnd = y_sq;        term_active = 1'b1; state_nxt = TY1; end
      TY1: begin coef = D; opnd = {4'b0, y_q}; term_active = 1'b1; state_nxt = TZ2; end
      TZ2: begin coef = E; opnd = z_sq;        term_active = 1'b1; state_nxt = TZ1; end
      TZ1: begin coef = F; opnd = {4'b0, z_q}; term_active = 1'b1; state_nxt = DONE; end
      DONE: begin
`ifdef QUAD_POLY_REARM_EN
        if (!en) state_nxt = IDLE;
`else
        state_nxt = DONE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      acc   <= '0;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && en) begin
        x_q <= in0;
        y_q <= in1;
        z_q <= in2;
        acc <= {{14{G[4]}}, G};
      end else if (term_active) begin
        acc <= acc + prod;
      end
      if (state == TZ1) out_q <= acc + prod;
    end
  end

  assign done = (state == DONE);
  assign out  = out_q;

endmodule
